// File: rtl/qsquare_pkg.sv
// Shared fixed-point definitions for the Q-format math library
// (qadd, qdiv, sqrt, qsquare): word width, fraction width, sign position
// and the saturated positive maximum.
package qsquare_pkg;

  localparam int QS_N        = 32;
  localparam int QS_Q        = 15;
  localparam int QS_SIGN_BIT = QS_N - 1;

  localparam logic [QS_N-1:0] QS_SAT_MAX = {1'b0, {(QS_N-1){1'b1}}};

  // Largest positive sign-magnitude value for an arbitrary word width.
  function automatic logic [63:0] qs_sat_max(input int unsigned width);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width - 1) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/qsquare.sv
// Sequential sign-magnitude fixed-point squarer.
// One multiplier bit per clock is folded into a full-width accumulator.
// After the last bit the product is rescaled by Q and saturated to the
// magnitude range. The operand sign is dropped because a square is never
// negative.
module qsquare
  import qsquare_pkg::*;
#(
  parameter int N = QS_N,
  parameter int Q = QS_Q
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] operand,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] square,
  output logic         overflow
);

  localparam int M  = N - 1;
  localparam int AW = 2 * M;
  localparam int CW = $clog2(M);

  localparam logic [CW-1:0] LAST_CNT = CW'(M - 1);
  localparam logic [63:0]   SAT_WIDE = qs_sat_max(N);
  localparam logic [N-1:0]  SAT_MAX  = SAT_WIDE[N-1:0];

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] mcand_q, mcand_d;
  logic [M-1:0]  mplier_q, mplier_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  square_q, square_d;
  logic          overflow_q, overflow_d;
  logic          valid_q, valid_d;

  logic [AW-1:0] acc_sum;
  logic [AW-1:M+Q] acc_high;
  logic [M+Q-1:Q]  acc_keep;
  logic          unused_bits;

  // Accumulator value after the current iteration. The multiplicand is
  // pre-shifted by one place per iteration, so bit 0 of the shifting
  // multiplier selects the addend.
  always_comb begin
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_high = acc_sum[AW-1:M+Q];
    acc_keep = acc_sum[M+Q-1:Q];
  end

  // The fraction bits dropped by truncation and the discarded sign are
  // intentionally unused.
  assign unused_bits = ^{acc_sum[Q-1:0], operand[N-1]};

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    square_d   = square_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = AW'(operand[N-2:0]);
          mplier_d = operand[N-2:0];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          valid_d = 1'b1;
          if (|acc_high) begin
            square_d   = SAT_MAX;
            overflow_d = 1'b1;
          end else begin
            square_d   = {1'b0, acc_keep};
            overflow_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      square_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      square_q   <= square_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign valid    = valid_q;
  assign square   = square_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_qsquare.sv
// Self-checking bench for qsquare: a transaction-level reference model
// (plain integer arithmetic plus a latency countdown) checked against the
// DUT on every cycle, directed cases with literal results, and a
// randomized traffic phase.
module tb_qsquare;

  localparam int N = 32;
  localparam int Q = 15;
  localparam int LATENCY = N - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] operand = '0;
  logic         busy;
  logic         valid;
  logic [N-1:0] square;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  qsquare #(.N(N), .Q(Q)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .operand  (operand),
    .busy     (busy),
    .valid    (valid),
    .square   (square),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Mathematical square of the magnitude, rescaled and saturated.
  // Result is {overflow, square}.
  function automatic logic [N:0] refSquare(input logic [N-1:0] op);
    logic [63:0] mag;
    logic [63:0] p;
    mag = {33'b0, op[N-2:0]};
    p   = (mag * mag) >> Q;
    if (p > 64'h0000_0000_7FFF_FFFF) begin
      return {1'b1, 1'b0, {(N-1){1'b1}}};
    end
    return {1'b0, p[N-1:0]};
  endfunction

  // Transaction model: an accepted operand produces its result after
  // LATENCY clocks. Requests arriving in the meantime are dropped.
  int           m_left = 0;
  logic         m_valid = 1'b0;
  logic         m_ovf = 1'b0;
  logic [N-1:0] m_square = '0;
  logic [N-1:0] m_op = '0;
  logic [N:0]   m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   = 0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
      m_square = '0;
    end else begin
      m_valid = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_res    = refSquare(m_op);
          m_valid  = 1'b1;
          m_ovf    = m_res[N];
          m_square = m_res[N-1:0];
        end
      end else if (start) begin
        m_op   = operand;
        m_left = LATENCY;
      end
    end
  end

  task automatic checkValue(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("busy", 64'(busy), 64'(m_left > 0));
    checkValue("valid", 64'(valid), 64'(m_valid));
    checkValue("square", 64'(square), 64'(m_square));
    checkValue("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput();
    end
  end

  task automatic applyStimulus(input logic [N-1:0] op);
    @(negedge clk);
    start   = 1'b1;
    operand = op;
    @(negedge clk);
    start   = 1'b0;
    operand = $urandom;
  endtask

  // Returns the number of falling edges until valid is seen, or -1.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runOne(input string name, input logic [N-1:0] op,
                        input logic [N-1:0] exp_sq, input logic exp_ovf);
    int lat;
    applyStimulus(op);
    waitValid(lat);
    checkValue({name, "_latency"}, 64'(lat), 64'(LATENCY));
    checkValue({name, "_square"}, 64'(square), 64'(exp_sq));
    checkValue({name, "_overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  initial begin
    int  lat;
    bit  seen;

    $display("[TB] qsquare bench start");

    checkValue("model_1p0", 64'(refSquare(32'h0000_8000)), 64'h0_0000_8000);
    checkValue("model_m1p5", 64'(refSquare(32'h8000_C000)), 64'h0_0001_2000);
    checkValue("model_0p5", 64'(refSquare(32'h0000_4000)), 64'h0_0000_2000);
    checkValue("model_lsb", 64'(refSquare(32'h0000_0001)), 64'h0_0000_0000);
    checkValue("model_256", 64'(refSquare(32'h0080_0000)), 64'h1_7FFF_FFFF);
    checkValue("model_2p0", 64'(refSquare(32'h0001_0000)), 64'h0_0002_0000);

    repeat (2) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    checkValue("reset_busy", 64'(busy), 64'h0);
    checkValue("reset_valid", 64'(valid), 64'h0);
    checkValue("reset_square", 64'(square), 64'h0);
    checkValue("reset_overflow", 64'(overflow), 64'h0);

    runOne("one",       32'h0000_8000, 32'h0000_8000, 1'b0);
    runOne("neg1p5",    32'h8000_C000, 32'h0001_2000, 1'b0);
    runOne("half",      32'h0000_4000, 32'h0000_2000, 1'b0);
    runOne("lsb",       32'h0000_0001, 32'h0000_0000, 1'b0);
    runOne("negzero",   32'h8000_0000, 32'h0000_0000, 1'b0);
    runOne("sat256",    32'h0080_0000, 32'h7FFF_FFFF, 1'b1);
    runOne("two",       32'h0001_0000, 32'h0002_0000, 1'b0);

    // Back-to-back: start asserted in the valid cycle.
    start   = 1'b1;
    operand = 32'h8000_C000;
    @(negedge clk);
    start   = 1'b0;
    waitValid(lat);
    checkValue("b2b_latency", 64'(lat), 64'(LATENCY));
    checkValue("b2b_square", 64'(square), 64'h0001_2000);

    // A start pulsed mid-operation is ignored.
    applyStimulus(32'h0001_0000);
    repeat (10) @(negedge clk);
    start   = 1'b1;
    operand = 32'h0080_0000;
    @(negedge clk);
    start   = 1'b0;
    waitValid(lat);
    checkValue("ignore_latency", 64'(lat), 64'(LATENCY - 11));
    checkValue("ignore_square", 64'(square), 64'h0002_0000);
    checkValue("ignore_overflow", 64'(overflow), 64'h0);

    // Reset at iteration 10 aborts the operation immediately.
    applyStimulus(32'h0000_C000);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkValue("abort_busy", 64'(busy), 64'h0);
    checkValue("abort_valid", 64'(valid), 64'h0);
    checkValue("abort_square", 64'(square), 64'h0);
    checkValue("abort_overflow", 64'(overflow), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    checkValue("abort_no_valid", 64'(seen), 64'h0);
    runOne("recover", 32'h0000_4000, 32'h0000_2000, 1'b0);

    // Randomized traffic, including starts issued while busy.
    for (int c = 0; c < 3000; c++) begin
      logic [N-2:0] raw;
      @(negedge clk);
      raw     = (N-1)'($urandom) >> $urandom_range(0, N - 2);
      start   = ($urandom_range(0, 3) == 0);
      operand = {1'($urandom), raw};
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
